// File: rtl/sisc_fetch_if.sv
// sisc_fetch_if: instruction-memory handshake plus core-side ir/branch
// signals of the SISC fetch stage. The master modport is the fetch stage
// and the slave modport is the memory/core environment around it.
interface sisc_fetch_if #(
    parameter int AW = 16,
    parameter int IW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] ir;
    logic          ir_valid;
    logic [AW-1:0] pc;
    logic          next_instr;
    logic          br_taken;
    logic          br_abs;
    logic [AW-1:0] br_imm;
    logic          halted;

    modport master (
        output imem_req, imem_addr, ir, ir_valid, pc, halted,
        input  imem_ack, imem_rdata, next_instr, br_taken, br_abs, br_imm
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_valid, pc, halted,
        output imem_ack, imem_rdata, next_instr, br_taken, br_abs, br_imm
    );
endinterface

// File: rtl/sisc_fetch.sv
// sisc_fetch: SISC instruction fetch stage. Holds the PC, fetches over a
// req/ack handshake, presents ir with a valid flag until the control unit
// consumes it, and applies branch redirects at consumption time.
// Optional macro SISC_FETCH_HALT_DETECT_EN: stop fetching after consuming
// an instruction whose top nibble is 4'hF (HLT) until reset.
module sisc_fetch #(
    parameter int            AW       = 16,
    parameter int            IW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst_f,
    sisc_fetch_if.master bus
);

`ifdef SISC_FETCH_HALT_DETECT_EN
    typedef enum logic [1:0] {
        s_fetch,
        s_wait,
        s_hold,
        s_halted
    } state_t;
`else
    typedef enum logic [1:0] {
        s_fetch,
        s_wait,
        s_hold
    } state_t;
`endif

    state_t        state;
    logic [AW-1:0] pc_r;
    logic [IW-1:0] ir_r;
    logic          ir_valid_r;
    logic          req_r;
`ifdef SISC_FETCH_HALT_DETECT_EN
    logic          hlt_pend;
    logic          halted_r;
`endif

    // Fetch FSM: req is a registered copy of "state is WAIT" so that the
    // memory bus sees no combinational path from any input.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state      <= s_fetch;
            pc_r       <= RESET_PC;
            ir_r       <= '0;
            ir_valid_r <= 1'b0;
            req_r      <= 1'b0;
`ifdef SISC_FETCH_HALT_DETECT_EN
            hlt_pend   <= 1'b0;
            halted_r   <= 1'b0;
`endif
        end else begin
            case (state)
                s_fetch: begin
                    state <= s_wait;
                    req_r <= 1'b1;
                end
                s_wait: begin
                    if (bus.imem_ack) begin
                        ir_r       <= bus.imem_rdata;
                        ir_valid_r <= 1'b1;
                        pc_r       <= pc_r + AW'(1);
                        req_r      <= 1'b0;
                        state      <= s_hold;
`ifdef SISC_FETCH_HALT_DETECT_EN
                        hlt_pend   <= (bus.imem_rdata[IW-1 -: 4] == 4'hF);
`endif
                    end
                end
                s_hold: begin
                    if (bus.next_instr) begin
                        ir_valid_r <= 1'b0;
                        // pc already points past this instruction, so a
                        // relative target is taken from the incremented pc.
                        if (bus.br_taken) begin
                            pc_r <= bus.br_abs ? bus.br_imm : pc_r + bus.br_imm;
                        end
`ifdef SISC_FETCH_HALT_DETECT_EN
                        if (hlt_pend) begin
                            state    <= s_halted;
                            halted_r <= 1'b1;
                        end else begin
                            state <= s_fetch;
                        end
`else
                        state <= s_fetch;
`endif
                    end
                end
`ifdef SISC_FETCH_HALT_DETECT_EN
                s_halted: begin
                    state <= s_halted;
                end
`endif
                default: begin
                    state <= s_fetch;
                    req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_r;
    assign bus.imem_addr = pc_r;
    assign bus.ir        = ir_r;
    assign bus.ir_valid  = ir_valid_r;
    assign bus.pc        = pc_r;
`ifdef SISC_FETCH_HALT_DETECT_EN
    assign bus.halted    = halted_r;
`else
    assign bus.halted    = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: self-checking bench for sisc_fetch. Table of directed
// fetch/consume records, randomized fetches against a pc reference model,
// and hand-written sequences for spurious inputs, reset mid-WAIT, PC wrap
// from RESET_PC=0xFFFF, and HLT handling (SISC_FETCH_HALT_DETECT_EN).
module tb_sisc_fetch;

    logic clk = 1'b0;
    logic rst_f = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] model_pc;

    always #5 clk = ~clk;

    sisc_fetch_if #(.AW(16), .IW(32)) b ();
    sisc_fetch_if #(.AW(16), .IW(32)) b2 ();

    sisc_fetch #(.AW(16), .IW(32), .RESET_PC(16'h0000)) dut (
        .clk  (clk),
        .rst_f(rst_f),
        .bus  (b)
    );

    sisc_fetch #(.AW(16), .IW(32), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk  (clk),
        .rst_f(rst_f),
        .bus  (b2)
    );

    typedef struct {
        int          dly;
        logic [31:0] data;
        logic        tk;
        logic        ab;
        logic [15:0] imm;
        logic [15:0] exp_addr;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference next-pc: signed offset applied with integer arithmetic, then
    // reduced modulo 2^16.
    function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic tk,
                                             input logic ab, input logic [15:0] imm);
        int off;
        int sum;
        if (!tk) return pc;
        if (ab) return imm;
        off = (int'(imm) >= 32768) ? int'(imm) - 65536 : int'(imm);
        sum = (int'(pc) + off + 65536) % 65536;
        return sum[15:0];
    endfunction

    task automatic garbage_br();
        b.br_taken = 1'b1;
        b.br_abs   = 1'($urandom_range(0, 1));
        b.br_imm   = 16'($urandom);
    endtask

    // Called at a negedge. Waits for req, holds ack off for dly cycles while
    // checking req/addr stability, then returns the word.
    task automatic do_fetch(input int dly, input logic [31:0] data, input logic [15:0] exp_addr);
        int n = 0;
        logic [15:0] nx;
        garbage_br();
        while (b.imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", b.imem_req, 1);
        chk("fetch_addr", b.imem_addr, exp_addr);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("wait_req_stable", b.imem_req, 1);
            chk("wait_addr_stable", b.imem_addr, exp_addr);
        end
        b.imem_ack   = 1'b1;
        b.imem_rdata = data;
        @(negedge clk);
        b.imem_ack   = 1'b0;
        b.imem_rdata = $urandom;
        nx = exp_addr + 16'd1;
        chk("ir", b.ir, data);
        chk("ir_valid", b.ir_valid, 1);
        chk("req_drop", b.imem_req, 0);
        chk("pc_inc", b.pc, nx);
    endtask

    // Called at a negedge in HOLD: pulse next_instr with branch info, then
    // check consumption and the two-cycle restart of the request.
    task automatic consume(input logic tk, input logic ab, input logic [15:0] imm,
                           input logic [15:0] exp_pc);
        b.next_instr = 1'b1;
        b.br_taken   = tk;
        b.br_abs     = ab;
        b.br_imm     = imm;
        @(negedge clk);
        b.next_instr = 1'b0;
        garbage_br();
        chk("consumed_valid", b.ir_valid, 0);
        chk("consumed_req", b.imem_req, 0);
        chk("branch_pc", b.pc, exp_pc);
        @(negedge clk);
        chk("req_latency", b.imem_req, 1);
        chk("next_addr", b.imem_addr, exp_pc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [31:0] held_ir;
        logic        tk;
        logic        ab;
        logic [15:0] imm;
        logic [15:0] npc;
        int          dly;

        b.imem_ack = 1'b0;  b.imem_rdata = '0; b.next_instr = 1'b0;
        b.br_taken = 1'b0;  b.br_abs = 1'b0;   b.br_imm = '0;
        b2.imem_ack = 1'b0; b2.imem_rdata = '0; b2.next_instr = 1'b0;
        b2.br_taken = 1'b0; b2.br_abs = 1'b0;   b2.br_imm = '0;

        tbl[0] = '{1, 32'h1123_4000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001};
        tbl[1] = '{0, 32'h2000_0001, 1'b0, 1'b1, 16'h1234, 16'h0001, 16'h0002};
        tbl[2] = '{3, 32'h3000_0002, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0003};
        tbl[3] = '{1, 32'h4000_0003, 1'b0, 1'b0, 16'h0000, 16'h0003, 16'h0004};
        tbl[4] = '{5, 32'h5000_0004, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0005};
        tbl[5] = '{0, 32'h6000_0005, 1'b1, 1'b0, 16'hFFFC, 16'h0005, 16'h0002};
        tbl[6] = '{2, 32'h7000_0006, 1'b1, 1'b1, 16'h0040, 16'h0002, 16'h0040};
        tbl[7] = '{0, 32'h8000_0007, 1'b1, 1'b1, 16'hFFFF, 16'h0040, 16'hFFFF};
        tbl[8] = '{1, 32'h9000_0008, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000};
        tbl[9] = '{0, 32'hA000_0009, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0004};

        // Reset state
        repeat (3) @(negedge clk);
        rst_f = 1'b0;
        chk("rst_pc", b.pc, 16'h0000);
        chk("rst_ir", b.ir, 32'h0);
        chk("rst_ir_valid", b.ir_valid, 0);
        chk("rst_req", b.imem_req, 0);
        chk("rst_halted", b.halted, 0);
        chk("rst_pc_wrapdut", b2.pc, 16'hFFFF);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_fetch(tbl[i].dly, tbl[i].data, tbl[i].exp_addr);
            consume(tbl[i].tk, tbl[i].ab, tbl[i].imm, tbl[i].exp_pc);
        end
        model_pc = 16'h0004;

        // Randomized fetches against the reference model
        for (int i = 0; i < 30; i++) begin
            dly = $urandom_range(0, 4);
            d   = $urandom & 32'hEFFF_FFFF;
            tk  = 1'($urandom_range(0, 1));
            ab  = 1'($urandom_range(0, 1));
            imm = 16'($urandom);
            do_fetch(dly, d, model_pc);
            model_pc = model_pc + 16'd1;
            npc = ref_next(model_pc, tk, ab, imm);
            consume(tk, ab, imm, npc);
            model_pc = npc;
        end

        // Spurious ack in HOLD, spurious next_instr in WAIT
        do_fetch(0, 32'h1357_9BDF, model_pc);
        model_pc = model_pc + 16'd1;
        held_ir = b.ir;
        b.imem_ack = 1'b1;
        b.imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        b.imem_ack = 1'b0;
        chk("hold_ack_ir", b.ir, held_ir);
        chk("hold_ack_valid", b.ir_valid, 1);
        chk("hold_ack_pc", b.pc, model_pc);
        chk("hold_ack_req", b.imem_req, 0);
        consume(1'b0, 1'b0, 16'h0000, model_pc);
        b.next_instr = 1'b1;
        b.br_taken = 1'b1;
        b.br_abs = 1'b1;
        b.br_imm = 16'h1234;
        @(negedge clk);
        b.next_instr = 1'b0;
        chk("wait_ni_req", b.imem_req, 1);
        chk("wait_ni_addr", b.imem_addr, model_pc);
        chk("wait_ni_pc", b.pc, model_pc);
        do_fetch(1, 32'h2468_ACE0, model_pc);
        model_pc = model_pc + 16'd1;
        consume(1'b0, 1'b0, 16'h0000, model_pc);

        // Reset mid-WAIT with ack held high
        #2;
        rst_f = 1'b1;
        b.imem_ack = 1'b1;
        b.imem_rdata = 32'h5555_5555;
        #1;
        chk("rst_async_req", b.imem_req, 0);
        chk("rst_async_pc", b.pc, 16'h0000);
        chk("rst_async_ir", b.ir, 32'h0);
        repeat (2) @(negedge clk);
        rst_f = 1'b0;
        @(negedge clk);
        b.imem_ack = 1'b0;
        chk("post_rst_valid", b.ir_valid, 0);
        chk("post_rst_req", b.imem_req, 1);
        chk("post_rst_addr", b.imem_addr, 16'h0000);
        model_pc = 16'h0000;
        do_fetch(0, 32'h0BAD_CAFE, model_pc);
        model_pc = model_pc + 16'd1;
        consume(1'b0, 1'b0, 16'h0000, model_pc);

        // RESET_PC=0xFFFF: pc wraps after one fetch
        chk("wrap_req", b2.imem_req, 1);
        chk("wrap_addr0", b2.imem_addr, 16'hFFFF);
        b2.imem_ack = 1'b1;
        b2.imem_rdata = 32'h1111_2222;
        @(negedge clk);
        b2.imem_ack = 1'b0;
        chk("wrap_ir", b2.ir, 32'h1111_2222);
        chk("wrap_pc", b2.pc, 16'h0000);
        b2.next_instr = 1'b1;
        @(negedge clk);
        b2.next_instr = 1'b0;
        @(negedge clk);
        chk("wrap_next_req", b2.imem_req, 1);
        chk("wrap_next_addr", b2.imem_addr, 16'h0000);

        // HLT word
        do_fetch(1, 32'hF000_0000, model_pc);
        model_pc = model_pc + 16'd1;
`ifdef SISC_FETCH_HALT_DETECT_EN
        begin
            int req_hi = 0;
            b.next_instr = 1'b1;
            b.br_taken = 1'b0;
            @(negedge clk);
            b.next_instr = 1'b0;
            chk("halt_flag", b.halted, 1);
            chk("halt_valid", b.ir_valid, 0);
            for (int i = 0; i < 20; i++) begin
                b.imem_ack = 1'($urandom_range(0, 1));
                b.next_instr = 1'($urandom_range(0, 1));
                garbage_br();
                @(negedge clk);
                if (b.imem_req !== 1'b0) req_hi++;
            end
            b.imem_ack = 1'b0;
            b.next_instr = 1'b0;
            chk("halt_req_cycles", req_hi, 0);
            chk("halt_flag_held", b.halted, 1);
            chk("halt_pc", b.pc, model_pc);
        end
`else
        consume(1'b0, 1'b0, 16'h0000, model_pc);
        chk("no_halt_flag", b.halted, 0);
        do_fetch(1, 32'h1234_5678, model_pc);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
- Instruction fetch stage directly upstream of the SISC core; produces the 32-bit `ir` word the core decodes.
- Holds the program counter (PC) and fetches from instruction memory over a req/ack handshake.
- Presents `ir` with a valid flag and holds it until the core's control unit signals consumption.
- Applies branch redirects supplied by the control unit at consumption time.

Parameters:
- AW, 16, PC / instruction-address width.
- IW, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_f  input  1  asynchronous, active-high reset; asserted high clears all state immediately.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  AW  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  memory response; imem_rdata is valid in the same cycle.
- imem_rdata  input  IW  fetched instruction word.
- ir  output  IW  instruction register presented to the core.
- ir_valid  output  1  ir holds a fetched, unconsumed instruction.
- pc  output  AW  current PC, i.e. the address of the next fetch.
- next_instr  input  1  one-cycle pulse from control: current ir consumed.
- br_taken  input  1  qualifies a redirect; sampled only with next_instr.
- br_abs  input  1  1 = absolute target, 0 = PC-relative.
- br_imm  input  AW  branch target (absolute) or two's-complement offset (relative).
- halted  output  1  fetch stopped on HLT; see Optional Feature.

Behaviour:
- Reset values: state=FETCH, pc=RESET_PC, ir=0 (NOP), ir_valid=0, imem_req=0, halted=0.
- imem_req and imem_addr are decoded from registered state only; no combinational path from inputs.
- States and transitions:
  - FETCH: imem_req=0. Next cycle goes to WAIT (one-cycle bubble).
  - WAIT: imem_req=1, imem_addr=pc, both held stable until imem_ack.
    - On imem_ack: ir<=imem_rdata, ir_valid<=1, pc<=pc+1, next state HOLD.
    - Without imem_ack: remain in WAIT indefinitely (no timeout).
  - HOLD: imem_req=0; ir and ir_valid held.
    - On next_instr: ir_valid<=0, next state FETCH.
    - pc update on next_instr: if br_taken and br_abs, pc<=br_imm; if br_taken and not br_abs, pc<=pc+br_imm (pc already points at the following instruction); otherwise pc unchanged.
- Latency:
  - imem_ack to ir_valid=1: 1 cycle.
  - next_instr to imem_req=1: 2 cycles.
  - Steady-state throughput: one instruction per 3 cycles plus memory wait.
- Arithmetic: all pc math is modulo 2^AW; 0xFFFF+1 wraps to 0x0000 (AW=16). Relative offsets are sign-interpreted; the sum is truncated to AW bits.
- Ignored inputs:
  - next_instr outside HOLD.
  - br_taken/br_abs/br_imm without next_instr.
  - imem_ack outside WAIT.
- Simultaneous events: none possible in a single state, since ack is honoured only in WAIT and next_instr only in HOLD.
- ir keeps its last value after consumption (ir_valid=0); the core must qualify on ir_valid.
- Reset mid-operation: any in-flight request is abandoned. imem_req drops asynchronously; ack arriving during reset or in the following FETCH cycle is discarded. Memory must drop ack once req deasserts.

Optional Feature:
- Macro: SISC_FETCH_HALT_DETECT_EN.
- Defined:
  - On capture of a word with imem_rdata[31:28]==4'hF (HLT), the instruction is loaded as normal (ir_valid=1, pc+1).
  - On its next_instr the FSM enters HALTED instead of FETCH: halted=1, imem_req=0, and all further inputs are ignored until rst_f.
- Undefined: opcode 4'hF is treated like any other word; halted is tied 0 and HALTED does not exist.

Test Plan:
- Reset then ack after 1 wait cycle with rdata=32'h1123_4000 → imem_addr=0x0000 while req=1; ir=32'h1123_4000 and ir_valid=1 one cycle after ack; pc=0x0001.
- Sequential run: 4 fetches with ack delays 0, 3, 1, 5 and a next_instr pulse each → addresses 0,1,2,3 in order; req/addr stable throughout each wait.
- With pc=0x0006 in HOLD, next_instr with br_taken=1, br_abs=0, br_imm=0xFFFC → next fetch addr 0x0002. Repeat with br_abs=1, br_imm=0x0040 → addr 0x0040.
- RESET_PC=0xFFFF, fetch one word → pc wraps to 0x0000 and the next imem_addr=0x0000. Spurious next_instr during WAIT and spurious ack during HOLD → no state change.
- Assert rst_f mid-WAIT for 2 cycles with ack held high → imem_req=0 immediately; after release pc=RESET_PC, ir_valid=0, and the first fetch restarts at RESET_PC.
- With the macro defined, fetch 32'hF000_0000 then pulse next_instr → halted=1 and imem_req stays 0 for 20 cycles; without the macro → a normal fetch of the next address.
